alu_deco: RTL and testbench



---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_deco_comb.sv | 40 ++++
 rtl/alu_deco.sv | 42 ++++
 tb/tb_alu_deco.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU decoder.
//   aluOp classes from the main decoder, aluControl selects for the ALU,
//   and the R-type func3 values the decoder understands.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_XOR = 3'b100;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/alu_deco_comb.sv
// Pure combinational ALU decode.
//   aluOp      : operation class from main decoder
//   func3      : instruction bits [14:12]
//   func7      : instruction bit 30 (add/sub select for R-type)
//   aluControl : next ALU operation select
//   illegal    : next flag for unsupported R-type func3
module alu_deco_comb
  import alu_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [2:0] func3,
  input  logic       func7,
  output logic [2:0] aluControl,
  output logic       illegal
);

  always_comb begin
    aluControl = ALUC_ADD;
    illegal    = 1'b0;
    case (aluOp)
      ALUOP_ADD:    aluControl = ALUC_ADD;
      ALUOP_BRANCH: aluControl = ALUC_SUB;
      ALUOP_RTYPE: begin
        case (func3)
          F3_ADDSUB: aluControl = func7 ? ALUC_SUB : ALUC_ADD;
          F3_SLT:    aluControl = ALUC_SLT;
          F3_XOR:    aluControl = ALUC_XOR;
          F3_OR:     aluControl = ALUC_OR;
          F3_AND:    aluControl = ALUC_AND;
          // func3 001, 011, 101 decode to add with illegal set
          default:   illegal    = 1'b1;
        endcase
      end
      // reserved class falls back to add without raising illegal
      ALUOP_RSVD:   aluControl = ALUC_ADD;
      default:      aluControl = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/alu_deco.sv
// ALU decoder with registered outputs (one-cycle latency).
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset, priority over decode
//   aluOp      : operation class from main decoder
//   func3      : instruction bits [14:12]
//   func7      : instruction bit 30
//   aluControl : registered ALU operation select
//   illegal    : registered unsupported-encoding flag
module alu_deco
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] aluOp,
  input  logic [2:0] func3,
  input  logic       func7,
  output logic [2:0] aluControl,
  output logic       illegal
);

  logic [2:0] next_aluc;
  logic       next_illegal;

  alu_deco_comb u_comb (
    .aluOp      (aluOp),
    .func3      (func3),
    .func7      (func7),
    .aluControl (next_aluc),
    .illegal    (next_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      aluControl <= '0;
      illegal    <= 1'b0;
    end else begin
      aluControl <= next_aluc;
      illegal    <= next_illegal;
    end
  end

endmodule

// File: tb/tb_alu_deco.sv
module tb_alu_deco;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] aluOp;
  logic [2:0] func3;
  logic       func7;
  logic [2:0] aluControl;
  logic       illegal;

  typedef struct {
    logic [2:0] aluc;
    logic       ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_deco dut (
    .clk        (clk),
    .reset      (reset),
    .aluOp      (aluOp),
    .func3      (func3),
    .func7      (func7),
    .aluControl (aluControl),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic rst, input logic [1:0] op,
                                 input logic [2:0] f3, input logic f7);
    exp_t e;
    e.aluc = 3'b000;
    e.ill  = 1'b0;
    if (!rst) begin
      if (op == 2'b01) e.aluc = 3'b001;
      else if (op == 2'b10) begin
        if (f3 == 3'b000)      e.aluc = f7 ? 3'b001 : 3'b000;
        else if (f3 == 3'b010) e.aluc = 3'b101;
        else if (f3 == 3'b100) e.aluc = 3'b100;
        else if (f3 == 3'b110) e.aluc = 3'b011;
        else if (f3 == 3'b111) e.aluc = 3'b010;
        else                   e.ill  = 1'b1;
      end
    end
    return e;
  endfunction

  // Drive one cycle of inputs, predict, then compare after the edge.
  task automatic step(input logic rst, input logic [1:0] op, input logic [2:0] f3,
                      input logic f7, input string tag);
    exp_t e;
    reset = rst;
    aluOp = op;
    func3 = f3;
    func7 = f7;
    sb.push_back(model(rst, op, f3, f7));
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (aluControl === e.aluc) else begin
        errors++;
        $error("FAIL %s aluControl got %b exp %b", tag, aluControl, e.aluc);
      end
      checks++;
      assert (illegal === e.ill) else begin
        errors++;
        $error("FAIL %s illegal got %b exp %b", tag, illegal, e.ill);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    aluOp = 2'b01;
    func3 = 3'b000;
    func7 = 1'b0;

    // reset held two edges with branch class pending
    step(1'b1, 2'b01, 3'b000, 1'b0, "reset0");
    step(1'b1, 2'b01, 3'b000, 1'b0, "reset1");
    step(1'b0, 2'b01, 3'b000, 1'b0, "rst_release");

    // non-R classes ignore func3/func7
    step(1'b0, 2'b00, 3'b101, 1'b1, "lwsw_a");
    step(1'b0, 2'b00, 3'b010, 1'b0, "lwsw_b");
    step(1'b0, 2'b01, 3'b111, 1'b1, "beq_a");
    step(1'b0, 2'b01, 3'b001, 1'b0, "beq_b");
    step(1'b0, 2'b11, 3'b000, 1'b0, "rsvd_a");
    step(1'b0, 2'b11, 3'b011, 1'b1, "rsvd_b");

    // R-type add/sub
    step(1'b0, 2'b10, 3'b000, 1'b0, "r_add");
    step(1'b0, 2'b10, 3'b000, 1'b1, "r_sub");

    // R-type logic/compare with func7 both ways
    step(1'b0, 2'b10, 3'b010, 1'b0, "r_slt0");
    step(1'b0, 2'b10, 3'b010, 1'b1, "r_slt1");
    step(1'b0, 2'b10, 3'b110, 1'b0, "r_or0");
    step(1'b0, 2'b10, 3'b110, 1'b1, "r_or1");
    step(1'b0, 2'b10, 3'b111, 1'b0, "r_and0");
    step(1'b0, 2'b10, 3'b111, 1'b1, "r_and1");
    step(1'b0, 2'b10, 3'b100, 1'b0, "r_xor0");
    step(1'b0, 2'b10, 3'b100, 1'b1, "r_xor1");

    // unsupported encodings, each followed by recovery to and
    step(1'b0, 2'b10, 3'b001, 1'b0, "r_sll");
    step(1'b0, 2'b10, 3'b111, 1'b0, "r_and_after_sll");
    step(1'b0, 2'b10, 3'b011, 1'b1, "r_sltu");
    step(1'b0, 2'b10, 3'b111, 1'b1, "r_and_after_sltu");
    step(1'b0, 2'b10, 3'b101, 1'b1, "r_sra");
    step(1'b0, 2'b10, 3'b111, 1'b0, "r_and_after_sra");

    // back-to-back sweep of all func3, alternating func7
    for (int i = 0; i < 8; i++)
      step(1'b0, 2'b10, 3'(i), 1'(i & 1), $sformatf("sweep_f3_%0d", i));
    for (int i = 7; i >= 0; i--)
      step(1'b0, 2'b10, 3'(i), 1'((i + 1) & 1), $sformatf("sweep_dn_%0d", i));

    // mid-stream reset and release
    step(1'b0, 2'b10, 3'b110, 1'b0, "pre_rst");
    step(1'b1, 2'b10, 3'b001, 1'b0, "mid_rst");
    step(1'b0, 2'b10, 3'b001, 1'b0, "post_rst_illegal");
    step(1'b0, 2'b01, 3'b000, 1'b0, "post_rst_beq");

    // random back-to-back traffic
    for (int i = 0; i < 40; i++)
      step(1'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), $sformatf("rand_%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
